// File: rtl/req_encoder_4to2.sv
// -----------------------------------------------------------------------------
// req_encoder_4to2
//
// Registered 4-to-2 request encoder. Request pulses on four lines are collected
// into a sticky pending register. One pending request at a time is granted and
// presented as a 2-bit index over a valid/ready handshake. This is the inverse
// of the 2-to-4 one-hot decoder that the consumer drives with the index.
//
// Parameters:
//   DRAIN_WHEN_DISABLED : 1 = pending bits keep being granted while enable=0
//                         0 = new grants stall while enable=0
//
// Optional feature (compile-time macro REQ_ENCODER_RR_PRIORITY_EN):
//   undefined : fixed priority 3 > 2 > 1 > 0, no pointer register
//   defined   : round-robin; the search runs downward with wrap, starting one
//               below the last granted index
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   enable  in   1 = req is sampled into pending, 0 = req is ignored
//   req     in   [3:0] request lines, level sampled every cycle
//   ready   in   consumer takes sel this cycle when valid=1
//   sel     out  [1:0] encoded index of the current grant
//   valid   out  sel holds a grant that has not been accepted yet
//   multi   out  more than one pending bit existed when the grant was chosen
//   pending out  [3:0] sticky pending-request register
// -----------------------------------------------------------------------------
module req_encoder_4to2 #(
    parameter bit DRAIN_WHEN_DISABLED = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [3:0] req,
    input  logic       ready,
    output logic [1:0] sel,
    output logic       valid,
    output logic       multi,
    output logic [3:0] pending
);

    // Number of set bits in a 4-bit vector.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

`ifdef REQ_ENCODER_RR_PRIORITY_EN
    // Round-robin pick: candidates are ptr-1, ptr-2, ptr-3, ptr (mod 4).
    // Walking from the lowest-precedence candidate up lets the first
    // candidate overwrite everything else when it is pending.
    function automatic logic [1:0] pick_grant(input logic [3:0] v,
                                              input logic [1:0] ptr_v);
        logic [1:0] idx;
        pick_grant = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_v - 2'd1 - 2'(k);
            if (v[idx]) begin
                pick_grant = idx;
            end else begin
                pick_grant = pick_grant;
            end
        end
    endfunction
`else
    // Fixed priority pick: highest index wins.
    function automatic logic [1:0] pick_grant(input logic [3:0] v);
        if (v[3]) begin
            pick_grant = 2'd3;
        end else if (v[2]) begin
            pick_grant = 2'd2;
        end else if (v[1]) begin
            pick_grant = 2'd1;
        end else begin
            pick_grant = 2'd0;
        end
    endfunction
`endif

    logic [3:0] pending_q, pending_d;
    logic [1:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic       multi_q, multi_d;
`ifdef REQ_ENCODER_RR_PRIORITY_EN
    logic [1:0] ptr_q, ptr_d;
`endif

    logic       accept_s;
    logic       load_ok_s;
    logic       issue_s;
    logic [1:0] grant_s;
    logic [3:0] clr_s;

    // Handshake, grant selection and next-state computation.
    always_comb begin
        accept_s  = valid_q & ready;
        load_ok_s = ~valid_q | accept_s;
        issue_s   = load_ok_s & (|pending_q) & (enable | DRAIN_WHEN_DISABLED);
`ifdef REQ_ENCODER_RR_PRIORITY_EN
        grant_s   = pick_grant(pending_q, ptr_q);
        ptr_d     = ptr_q;
`else
        grant_s   = pick_grant(pending_q);
`endif
        sel_d     = sel_q;
        valid_d   = valid_q;
        multi_d   = multi_q;

        if (issue_s) begin
            sel_d   = grant_s;
            valid_d = 1'b1;
            multi_d = (popcount4(pending_q) > 3'd1);
`ifdef REQ_ENCODER_RR_PRIORITY_EN
            ptr_d   = grant_s;
`endif
        end else if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (issue_s) begin
            clr_s = 4'b0001 << grant_s;
        end else begin
            clr_s = 4'b0000;
        end

        // Set after clear: a request arriving on the bit being granted
        // keeps it pending for a later grant.
        pending_d = (pending_q & ~clr_s) | (enable ? req : 4'b0000);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 4'b0000;
            sel_q     <= 2'b00;
            valid_q   <= 1'b0;
            multi_q   <= 1'b0;
`ifdef REQ_ENCODER_RR_PRIORITY_EN
            ptr_q     <= 2'b00;
`endif
        end else begin
            pending_q <= pending_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            multi_q   <= multi_d;
`ifdef REQ_ENCODER_RR_PRIORITY_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign sel     = sel_q;
    assign valid   = valid_q;
    assign multi   = multi_q;
    assign pending = pending_q;

endmodule
